// File: rtl/axi_seq_pkg.sv
// Shared definitions for the AW/W write-path sequencer: AXI length width and
// the type of one entry in the outstanding-burst length fifo.
package axi_seq_pkg;

  localparam int unsigned AXI_LEN_WIDTH = 8;

  typedef logic [AXI_LEN_WIDTH-1:0] len_t;

endpackage

// File: rtl/axi_aw_w_sequencer_fifo.sv
// Generic synchronous fifo with optional fall-through. Occupancy is tracked by
// a counter so DEPTH does not have to be a power of two.
module axi_aw_w_sequencer_fifo #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH        = 4,
  parameter bit          FALL_THROUGH = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  mem_empty;
  logic                  bypass;
  logic                  push_mem;
  logic                  pop_mem;
  logic                  unused_testmode;

  assign unused_testmode = testmode_i;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign mem_empty = (count == '0);
  assign full_o    = (count == CNT_W'(DEPTH));
  // In fall-through mode an entry pushed into an empty fifo is visible at once;
  // if it is also popped in that cycle it never touches the storage.
  assign bypass    = FALL_THROUGH && mem_empty && push_i;
  assign empty_o   = mem_empty & ~bypass;
  assign data_o    = bypass ? data_i : mem[rd_ptr];
  assign push_mem  = push_i & ~full_o & ~(bypass & pop_i);
  assign pop_mem   = pop_i & ~mem_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_mem) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_mem)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push_mem) - CNT_W'(pop_mem);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_mem) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/axi_aw_w_sequencer.sv
// Holds W beats back until their AW has gone downstream, regenerates WLAST from
// a beat count against AWLEN, and flags upstream WLAST disagreements.
module axi_aw_w_sequencer
  import axi_seq_pkg::*;
#(
  parameter int unsigned AW_WIDTH        = 64,
  parameter int unsigned W_WIDTH         = 72,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     testmode_i,
  input  logic                     aw_valid_i,
  output logic                     aw_ready_o,
  input  logic [AXI_LEN_WIDTH-1:0] aw_len_i,
  input  logic [AW_WIDTH-1:0]      aw_data_i,
  output logic                     aw_valid_o,
  input  logic                     aw_ready_i,
  output logic [AXI_LEN_WIDTH-1:0] aw_len_o,
  output logic [AW_WIDTH-1:0]      aw_data_o,
  input  logic                     w_valid_i,
  output logic                     w_ready_o,
  input  logic [W_WIDTH-1:0]       w_data_i,
  input  logic                     w_last_i,
  output logic                     w_valid_o,
  input  logic                     w_ready_i,
  output logic [W_WIDTH-1:0]       w_data_o,
  output logic                     w_last_o,
  output logic                     last_err_o,
  output logic                     busy_o
);

  logic len_full;
  logic len_empty;
  len_t len_head;
  len_t beat_cnt;
  logic aw_hs;
  logic w_hs;

  // Full blocks AW even on a same-cycle pop, keeping W ready out of the AW path.
  assign aw_valid_o = aw_valid_i & ~len_full;
  assign aw_ready_o = aw_ready_i & ~len_full;
  assign aw_len_o   = aw_len_i;
  assign aw_data_o  = aw_data_i;
  assign aw_hs      = aw_valid_o & aw_ready_i;

  assign w_valid_o  = w_valid_i & ~len_empty;
  assign w_ready_o  = w_ready_i & ~len_empty;
  assign w_data_o   = w_data_i;
  assign w_last_o   = ~len_empty & (beat_cnt == len_head);
  assign w_hs       = w_valid_o & w_ready_i;
  assign busy_o     = ~len_empty;

  axi_aw_w_sequencer_fifo #(
    .DATA_WIDTH   (AXI_LEN_WIDTH),
    .DEPTH        (MAX_OUTSTANDING),
    .FALL_THROUGH (1'b0)
  ) i_len_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (1'b0),
    .testmode_i (testmode_i),
    .full_o     (len_full),
    .empty_o    (len_empty),
    .data_i     (aw_len_i),
    .push_i     (aw_hs),
    .data_o     (len_head),
    .pop_i      (w_hs & w_last_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt   <= '0;
      last_err_o <= 1'b0;
    end else begin
      last_err_o <= w_hs & (w_last_i != w_last_o);
      if (w_hs) beat_cnt <= w_last_o ? '0 : beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_aw_w_sequencer.sv
module tb_axi_aw_w_sequencer;
  localparam int AW_WIDTH = 64;
  localparam int W_WIDTH  = 72;
  localparam int MAX_OUT  = 4;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                testmode_i = 1'b0;
  logic                aw_valid_i, aw_ready_o, aw_valid_o, aw_ready_i;
  logic [7:0]          aw_len_i, aw_len_o;
  logic [AW_WIDTH-1:0] aw_data_i, aw_data_o;
  logic                w_valid_i, w_ready_o, w_last_i, w_valid_o, w_ready_i, w_last_o;
  logic [W_WIDTH-1:0]  w_data_i, w_data_o;
  logic                last_err_o, busy_o;

  axi_aw_w_sequencer #(.AW_WIDTH(AW_WIDTH), .W_WIDTH(W_WIDTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .testmode_i(testmode_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_len_i(aw_len_i), .aw_data_i(aw_data_i),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_len_o(aw_len_o), .aw_data_o(aw_data_o),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i), .w_last_i(w_last_i),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_last_o(w_last_o),
    .last_err_o(last_err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of accepted bursts (total beats each), beats already
  // sent of the head burst, and the error flag due in the next cycle.
  int q[$];
  int done_beats = 0;
  bit err_q = 1'b0;
  bit e_full, e_empty, e_awv, e_awr, e_wv, e_wr, e_last, e_busy;

  task automatic model_eval();
    e_full  = (q.size() == MAX_OUT);
    e_empty = (q.size() == 0);
    e_awv   = aw_valid_i && !e_full;
    e_awr   = aw_ready_i && !e_full;
    e_wv    = w_valid_i && !e_empty;
    e_wr    = w_ready_i && !e_empty;
    e_last  = 1'b0;
    if (!e_empty) e_last = (done_beats == q[0] - 1);
    e_busy  = !e_empty;
  endtask

  task automatic model_reset();
    q.delete();
    done_beats = 0;
    err_q = 1'b0;
  endtask

  // Advance one clock; model follows the handshakes the spec rules imply.
  task automatic tick(output bit whs, output bit wlast);
    bit awhs;
    int alen;
    model_eval();
    whs   = e_wv && w_ready_i;
    wlast = e_last;
    awhs  = e_awv && aw_ready_i;
    alen  = int'(aw_len_i) + 1;
    err_q = whs && (w_last_i != e_last);
    @(posedge clk_i);
    if (whs) begin
      if (wlast) begin
        void'(q.pop_front());
        done_beats = 0;
      end else begin
        done_beats++;
      end
    end
    if (awhs) q.push_back(alen);
    #1;
  endtask

  task automatic idle();
    aw_valid_i = 0; aw_ready_i = 1; aw_len_i = 0; aw_data_i = '0;
    w_valid_i = 0; w_ready_i = 1; w_last_i = 0; w_data_i = '0;
  endtask

  task automatic test_reset();
    bit whs, wl;
    idle();
    aw_valid_i = 1; w_valid_i = 1;
    #2;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    checks++; if (w_valid_o !== 1'b0) begin errors++; $display("FAIL reset_wvalid got %b exp 0", w_valid_o); end
    checks++; if (aw_valid_o !== 1'b1) begin errors++; $display("FAIL reset_awvalid got %b exp 1", aw_valid_o); end
    checks++; if (last_err_o !== 1'b0) begin errors++; $display("FAIL reset_lasterr got %b exp 0", last_err_o); end
    @(posedge clk_i); #1;
    idle();
    rst_ni = 1;
    model_reset();
    tick(whs, wl);
  endtask

  task automatic test_single_beat();
    bit whs, wl;
    aw_valid_i = 1; aw_len_i = 0; w_valid_i = 1; w_last_i = 1;
    #1;
    checks++; if (aw_valid_o !== 1'b1) begin errors++; $display("FAIL sb_awvalid got %b exp 1", aw_valid_o); end
    checks++; if (w_valid_o !== 1'b0) begin errors++; $display("FAIL sb_wvalid_aw_cycle got %b exp 0", w_valid_o); end
    tick(whs, wl);
    aw_valid_i = 0;
    #1;
    checks++; if (w_valid_o !== 1'b1 || w_last_o !== 1'b1) begin errors++; $display("FAIL sb_beat got v%b l%b exp v1 l1", w_valid_o, w_last_o); end
    tick(whs, wl);
    w_valid_i = 0; w_last_i = 0;
    #1;
    checks++; if (busy_o !== 1'b0 || last_err_o !== 1'b0) begin errors++; $display("FAIL sb_after got busy%b err%b exp 0 0", busy_o, last_err_o); end
  endtask

  task automatic test_w_before_aw();
    bit whs, wl;
    int beats = 0;
    w_valid_i = 1; w_last_i = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin aw_valid_i = 1; aw_len_i = 3; end
      #1;
      checks++; if (w_valid_o !== 1'b0) begin errors++; $display("FAIL wba_gate c%0d got %b exp 0", c, w_valid_o); end
      tick(whs, wl);
    end
    aw_valid_i = 0;
    for (int c = 0; c < 4; c++) begin
      w_last_i = (c == 3);
      #1;
      checks++; if (w_valid_o !== 1'b1 || w_last_o !== (c == 3)) begin errors++; $display("FAIL wba_beat%0d got v%b l%b exp v1 l%0d", c, w_valid_o, w_last_o, c == 3); end
      tick(whs, wl);
      if (whs) beats++;
    end
    w_valid_i = 0; w_last_i = 0;
    #1;
    checks++; if (beats != 4 || busy_o !== 1'b0) begin errors++; $display("FAIL wba_done got beats%0d busy%b exp 4 0", beats, busy_o); end
  endtask

  task automatic test_outstanding();
    bit whs, wl;
    aw_valid_i = 1; aw_len_i = 1; w_valid_i = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (aw_ready_o !== 1'b1) begin errors++; $display("FAIL os_accept%0d got %b exp 1", c, aw_ready_o); end
      tick(whs, wl);
    end
    w_valid_i = 1;
    for (int c = 0; c < 2; c++) begin
      w_last_i = (c == 1);
      #1;
      checks++; if (aw_ready_o !== 1'b0 || aw_valid_o !== 1'b0) begin errors++; $display("FAIL os_full%0d got r%b v%b exp 0 0", c, aw_ready_o, aw_valid_o); end
      checks++; if (w_last_o !== (c == 1)) begin errors++; $display("FAIL os_last%0d got %b exp %0d", c, w_last_o, c == 1); end
      tick(whs, wl);
    end
    w_valid_i = 0; w_last_i = 0;
    #1;
    checks++; if (aw_ready_o !== 1'b1) begin errors++; $display("FAIL os_fifth got %b exp 1", aw_ready_o); end
    tick(whs, wl);
    aw_valid_i = 0;
    w_valid_i = 1;
    for (int c = 0; c < 8; c++) begin
      w_last_i = c[0];
      #1;
      model_eval();
      checks++; if (w_last_o !== e_last || w_valid_o !== e_wv) begin errors++; $display("FAIL os_drain%0d got l%b v%b exp l%b v%b", c, w_last_o, w_valid_o, e_last, e_wv); end
      tick(whs, wl);
    end
    w_valid_i = 0; w_last_i = 0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL os_empty got %b exp 0", busy_o); end
  endtask

  task automatic test_mismatch();
    bit whs, wl;
    aw_valid_i = 1; aw_len_i = 2;
    tick(whs, wl);
    aw_valid_i = 0; w_valid_i = 1;
    for (int c = 0; c < 3; c++) begin
      w_last_i = (c == 0);
      #1;
      checks++; if (w_last_o !== (c == 2)) begin errors++; $display("FAIL mm_last%0d got %b exp %0d", c, w_last_o, c == 2); end
      checks++; if (last_err_o !== (c == 1)) begin errors++; $display("FAIL mm_err%0d got %b exp %0d", c, last_err_o, c == 1); end
      tick(whs, wl);
    end
    w_valid_i = 0; w_last_i = 0;
    #1;
    checks++; if (last_err_o !== 1'b1) begin errors++; $display("FAIL mm_err_final got %b exp 1", last_err_o); end
    tick(whs, wl);
    checks++; if (last_err_o !== 1'b0) begin errors++; $display("FAIL mm_err_clear got %b exp 0", last_err_o); end
  endtask

  task automatic test_long_burst();
    bit whs, wl;
    int beats = 0;
    int lasts = 0;
    int cyc = 0;
    aw_valid_i = 1; aw_len_i = 255;
    tick(whs, wl);
    aw_valid_i = 0; w_valid_i = 1;
    while (beats < 256 && cyc < 3000) begin
      w_ready_i = 1'($urandom_range(0, 1));
      w_last_i  = (beats == 255);
      #1;
      model_eval();
      if (w_last_o !== e_last) begin checks++; errors++; $display("FAIL lb_last beat%0d got %b exp %b", beats, w_last_o, e_last); end
      if (w_valid_o && w_ready_i) begin
        beats++;
        if (w_last_o) lasts++;
      end
      tick(whs, wl);
      cyc++;
    end
    w_valid_i = 0; w_ready_i = 1; w_last_i = 0;
    #1;
    checks++; if (beats != 256 || lasts != 1) begin errors++; $display("FAIL lb_count got beats%0d lasts%0d exp 256 1", beats, lasts); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL lb_busy got %b exp 0", busy_o); end
    aw_valid_i = 1; aw_len_i = 0;
    tick(whs, wl);
    aw_valid_i = 0; w_valid_i = 1; w_last_i = 1;
    #1;
    checks++; if (w_last_o !== 1'b1) begin errors++; $display("FAIL lb_cnt_cleared got %b exp 1", w_last_o); end
    tick(whs, wl);
    w_valid_i = 0; w_last_i = 0;
  endtask

  task automatic test_reset_mid_burst();
    bit whs, wl;
    aw_valid_i = 1; aw_len_i = 7;
    tick(whs, wl);
    aw_valid_i = 0; w_valid_i = 1; w_last_i = 0;
    for (int c = 0; c < 3; c++) tick(whs, wl);
    rst_ni = 0; aw_valid_i = 1;
    #1;
    checks++; if (busy_o !== 1'b0 || w_valid_o !== 1'b0 || w_ready_o !== 1'b0) begin errors++; $display("FAIL rmb_immediate got busy%b wv%b wr%b exp 0 0 0", busy_o, w_valid_o, w_ready_o); end
    checks++; if (aw_valid_o !== 1'b1) begin errors++; $display("FAIL rmb_awvalid got %b exp 1", aw_valid_o); end
    @(posedge clk_i); #1;
    idle();
    rst_ni = 1;
    model_reset();
    aw_valid_i = 1; aw_len_i = 0;
    tick(whs, wl);
    aw_valid_i = 0; w_valid_i = 1; w_last_i = 1;
    #1;
    checks++; if (w_valid_o !== 1'b1 || w_last_o !== 1'b1) begin errors++; $display("FAIL rmb_new got v%b l%b exp 1 1", w_valid_o, w_last_o); end
    tick(whs, wl);
    w_valid_i = 0; w_last_i = 0;
    #1;
    checks++; if (busy_o !== 1'b0 || last_err_o !== 1'b0) begin errors++; $display("FAIL rmb_done got busy%b err%b exp 0 0", busy_o, last_err_o); end
  endtask

  task automatic test_random();
    bit whs, wl;
    int bad = 0;
    for (int c = 0; c < 400; c++) begin
      aw_valid_i = ($urandom_range(0, 3) == 0);
      aw_ready_i = ($urandom_range(0, 3) != 0);
      aw_len_i   = 8'($urandom_range(0, 3));
      aw_data_i  = {$urandom, $urandom};
      w_valid_i  = ($urandom_range(0, 3) != 0);
      w_ready_i  = ($urandom_range(0, 3) != 0);
      w_data_i   = {8'($urandom), $urandom, $urandom};
      model_eval();
      w_last_i   = ($urandom_range(0, 7) == 0) ? ~e_last : e_last;
      #1;
      model_eval();
      if (aw_valid_o !== e_awv || aw_ready_o !== e_awr || w_valid_o !== e_wv || w_ready_o !== e_wr ||
          w_last_o !== e_last || busy_o !== e_busy || last_err_o !== err_q ||
          aw_len_o !== aw_len_i || aw_data_o !== aw_data_i || w_data_o !== w_data_i) begin
        bad++;
        if (bad < 5) $display("FAIL rnd c%0d got awv%b awr%b wv%b wr%b l%b b%b e%b exp awv%b awr%b wv%b wr%b l%b b%b e%b",
          c, aw_valid_o, aw_ready_o, w_valid_o, w_ready_o, w_last_o, busy_o, last_err_o,
          e_awv, e_awr, e_wv, e_wr, e_last, e_busy, err_q);
      end
      tick(whs, wl);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rnd_total got %0d bad cycles exp 0", bad); end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single_beat();
    test_w_before_aw();
    test_outstanding();
    test_mismatch();
    test_long_burst();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
